// File: rtl/lz77_lookahead_controller.sv
// LZ77 lookahead controller: buffers a 7-byte window, issues searches,
// emits literal/match tokens and commits consumed bytes to history.
module lz77_lookahead_controller #(
  parameter int LOOKAHEAD   = 7,
  parameter int INDEX_WIDTH = 12,
  parameter int MIN_MATCH   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inDataValid,
  output logic                     inDataReady,
  input  logic [7:0]               inData,
  input  logic                     inLast,
  output logic                     patternDataValid,
  input  logic                     patternDataReady,
  output logic [8*LOOKAHEAD-1:0]   patternData,
  output logic [2:0]               patternDataLength,
  input  logic                     matchResultValid,
  output logic                     matchResultReady,
  input  logic [INDEX_WIDTH-1:0]   matchResultIndex,
  input  logic [2:0]               matchResultLength,
  output logic                     writeDataValid,
  input  logic                     writeDataReady,
  output logic [7:0]               writeData,
  output logic                     tokenValid,
  input  logic                     tokenReady,
  output logic                     tokenIsMatch,
  output logic [7:0]               tokenLiteral,
  output logic [INDEX_WIDTH-1:0]   tokenIndex,
  output logic [2:0]               tokenLength,
  output logic                     tokenLast
);

  typedef enum logic [2:0] {
    FILL, SEARCH, WAIT, EMIT, COMMIT
  } state_t;

  localparam logic [2:0] Full   = 3'(LOOKAHEAD);
  localparam logic [2:0] MinLen = 3'(MIN_MATCH);

  state_t                         state;
  logic [LOOKAHEAD-1:0][7:0]      buffer;
  logic [2:0]                     count;
  logic [2:0]                     consume;
  logic [2:0]                     matchLen;
  logic [INDEX_WIDTH-1:0]         matchIndex;
  logic                           lastSeen;

  logic       inFire;
  logic [2:0] fillCount;
  logic [2:0] stepLen;
  logic       lenOk;

  assign inFire    = inDataValid && inDataReady;
  assign fillCount = count + 3'd1;
  assign stepLen   = (matchLen != 3'd0) ? matchLen : 3'd1;
  // Out-of-range lengths fall back to a literal instead of stalling
  assign lenOk     = (matchResultLength >= MinLen) &&
                     (matchResultLength <= count);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      buffer     <= '0;
      count      <= '0;
      consume    <= '0;
      matchLen   <= '0;
      matchIndex <= '0;
      lastSeen   <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (inFire) begin
            buffer[count] <= inData;
            count         <= fillCount;
            if (inLast)
              lastSeen <= 1'b1;
            if (fillCount == Full || inLast)
              state <= SEARCH;
          end else if (lastSeen && count != 3'd0) begin
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (patternDataReady)
            state <= WAIT;
        end
        WAIT: begin
          if (matchResultValid) begin
            matchIndex <= matchResultIndex;
            matchLen   <= lenOk ? matchResultLength : 3'd0;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (tokenReady) begin
            consume <= stepLen;
            state   <= COMMIT;
          end
        end
        COMMIT: begin
          if (writeDataReady) begin
            buffer  <= {8'h00, buffer[LOOKAHEAD-1:1]};
            count   <= count - 3'd1;
            consume <= consume - 3'd1;
            if (consume == 3'd1) begin
              if (lastSeen && count == 3'd1)
                lastSeen <= 1'b0;
              state <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_comb begin
    inDataReady = (state == FILL) && (count < Full) && !lastSeen;

    patternDataValid  = (state == SEARCH);
    patternDataLength = (state == SEARCH) ? count : 3'd0;
    patternData       = '0;
    for (int i = 0; i < LOOKAHEAD; i++) begin
      if (state == SEARCH && 3'(i) < count)
        patternData[8*i +: 8] = buffer[i];
    end

    matchResultReady = (state == WAIT);

    tokenValid   = (state == EMIT);
    tokenIsMatch = 1'b0;
    tokenLiteral = '0;
    tokenIndex   = '0;
    tokenLength  = '0;
    tokenLast    = 1'b0;
    if (state == EMIT) begin
      tokenLast = lastSeen && (stepLen == count);
      if (matchLen != 3'd0) begin
        tokenIsMatch = 1'b1;
        tokenIndex   = matchIndex;
        tokenLength  = matchLen;
      end else begin
        tokenLiteral = buffer[0];
      end
    end

    writeDataValid = (state == COMMIT);
    writeData      = (state == COMMIT) ? buffer[0] : 8'h00;
  end

endmodule

// File: tb/tb_lz77_lookahead_controller.sv
// Directed bench for lz77_lookahead_controller with queued
// pattern/token/write expectations checked as the DUT hands them off.
module tb_lz77_lookahead_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inDataValid = 1'b0;
  logic        inDataReady;
  logic [7:0]  inData = '0;
  logic        inLast = 1'b0;
  logic        patternDataValid;
  logic        patternDataReady = 1'b0;
  logic [55:0] patternData;
  logic [2:0]  patternDataLength;
  logic        matchResultValid = 1'b0;
  logic        matchResultReady;
  logic [11:0] matchResultIndex = '0;
  logic [2:0]  matchResultLength = '0;
  logic        writeDataValid;
  logic        writeDataReady = 1'b1;
  logic [7:0]  writeData;
  logic        tokenValid;
  logic        tokenReady = 1'b1;
  logic        tokenIsMatch;
  logic [7:0]  tokenLiteral;
  logic [11:0] tokenIndex;
  logic [2:0]  tokenLength;
  logic        tokenLast;

  lz77_lookahead_controller dut (
    .clock(clock), .reset(reset),
    .inDataValid(inDataValid), .inDataReady(inDataReady),
    .inData(inData), .inLast(inLast),
    .patternDataValid(patternDataValid),
    .patternDataReady(patternDataReady),
    .patternData(patternData),
    .patternDataLength(patternDataLength),
    .matchResultValid(matchResultValid),
    .matchResultReady(matchResultReady),
    .matchResultIndex(matchResultIndex),
    .matchResultLength(matchResultLength),
    .writeDataValid(writeDataValid),
    .writeDataReady(writeDataReady),
    .writeData(writeData),
    .tokenValid(tokenValid), .tokenReady(tokenReady),
    .tokenIsMatch(tokenIsMatch), .tokenLiteral(tokenLiteral),
    .tokenIndex(tokenIndex), .tokenLength(tokenLength),
    .tokenLast(tokenLast)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [63:0] expPat[$];
  logic [63:0] expTok[$];
  logic [63:0] expWr[$];
  logic        held = 1'b0;
  logic [63:0] heldTok = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s got=none exp=event", tag);
  endtask

  function automatic logic [63:0] tok(input logic m, input logic lst,
      input logic [2:0] len, input logic [11:0] idx,
      input logic [7:0] lit);
    return 64'({m, lst, len, idx, lit});
  endfunction

  function automatic logic [63:0] tokNow();
    return 64'({tokenIsMatch, tokenLast, tokenLength,
                tokenIndex, tokenLiteral});
  endfunction

  function automatic logic [63:0] pat(input logic [2:0] len,
                                      input logic [55:0] data);
    return 64'({len, data});
  endfunction

  // Scoreboard: every handshake pops and compares the oldest expectation
  always @(negedge clock) begin
    if (!reset) begin
      if (patternDataValid && patternDataReady) begin
        if (expPat.size() == 0) fail("patUnexpected");
        else chk("pattern", pat(patternDataLength, patternData),
                 expPat.pop_front());
      end
      if (tokenValid && tokenReady) begin
        if (expTok.size() == 0) fail("tokUnexpected");
        else chk("token", tokNow(), expTok.pop_front());
      end
      if (writeDataValid && writeDataReady) begin
        if (expWr.size() == 0) fail("writeUnexpected");
        else chk("write", 64'(writeData), expWr.pop_front());
      end
      if (tokenValid && !tokenReady) begin
        if (held) chk("tokStable", tokNow(), heldTok);
        heldTok <= tokNow();
        held    <= 1'b1;
      end else begin
        held <= 1'b0;
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input logic last);
    int t = 0;
    inDataValid = 1'b1;
    inData      = b;
    inLast      = last;
    while (!inDataReady && t < 200) begin
      @(posedge clock); #1; t++;
    end
    if (!inDataReady) fail("sendTimeout");
    @(posedge clock); #1;
    inDataValid = 1'b0;
    inLast      = 1'b0;
    inData      = '0;
  endtask

  task automatic doSearch(input logic [2:0] len, input logic [11:0] idx);
    int t = 0;
    while (!patternDataValid && t < 200) begin
      @(posedge clock); #1; t++;
    end
    if (!patternDataValid) begin
      fail("patTimeout");
      return;
    end
    patternDataReady = 1'b1;
    @(posedge clock); #1;
    patternDataReady  = 1'b0;
    matchResultValid  = 1'b1;
    matchResultLength = len;
    matchResultIndex  = idx;
    t = 0;
    while (!matchResultReady && t < 200) begin
      @(posedge clock); #1; t++;
    end
    if (!matchResultReady) fail("resultTimeout");
    @(posedge clock); #1;
    matchResultValid  = 1'b0;
    matchResultLength = '0;
    matchResultIndex  = '0;
  endtask

  task automatic waitDrain(input string tag);
    int t = 0;
    while ((expTok.size() != 0 || expWr.size() != 0) && t < 300) begin
      @(posedge clock); #1; t++;
    end
    if (expTok.size() != 0 || expWr.size() != 0) fail(tag);
  endtask

  initial begin
    #12;
    chk("rstValids", 64'({patternDataValid, matchResultReady,
        writeDataValid, tokenValid}), 64'(0));
    chk("rstInReady", 64'(inDataReady), 64'(1));
    chk("rstData", 64'({patternDataLength, patternData}), 64'(0));
    chk("rstTok", tokNow(), 64'(0));
    chk("rstWrite", 64'(writeData), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;

    // full window, literal result
    expPat.push_back(pat(3'd7, 56'h47464544434241));
    for (int i = 0; i < 7; i++) sendByte(8'(8'h41 + i), 1'b0);
    expTok.push_back(tok(1'b0, 1'b0, 3'd0, 12'h0, 8'h41));
    expWr.push_back(64'h41);
    doSearch(3'd0, 12'h0);
    expPat.push_back(pat(3'd7, 56'h48474645444342));
    sendByte(8'h48, 1'b0);
    chk("refill1", 64'({inDataReady, patternDataValid}), 64'(1));

    // match of 3, then 3-byte refill mid-window
    expTok.push_back(tok(1'b1, 1'b0, 3'd3, 12'h123, 8'h00));
    expWr.push_back(64'h42);
    expWr.push_back(64'h43);
    expWr.push_back(64'h44);
    doSearch(3'd3, 12'h123);
    expPat.push_back(pat(3'd7, 56'h4B4A4948474645));
    sendByte(8'h49, 1'b0);
    sendByte(8'h4A, 1'b0);
    sendByte(8'h4B, 1'b0);
    chk("refill3", 64'({inDataReady, patternDataValid}), 64'(1));

    // length below minimum becomes a literal
    expTok.push_back(tok(1'b0, 1'b0, 3'd0, 12'h0, 8'h45));
    expWr.push_back(64'h45);
    doSearch(3'd1, 12'h0AA);
    expPat.push_back(pat(3'd7, 56'h4C4B4A49484746));
    sendByte(8'h4C, 1'b0);
    chk("refillMin", 64'({inDataReady, patternDataValid}), 64'(1));

    // match consuming the whole window
    expTok.push_back(tok(1'b1, 1'b0, 3'd7, 12'h005, 8'h00));
    for (int i = 0; i < 7; i++) expWr.push_back(64'(8'h46 + i));
    doSearch(3'd7, 12'h005);
    waitDrain("drainFull");
    chk("emptyReady", 64'(inDataReady), 64'(1));

    // short page: length above count becomes a literal
    expPat.push_back(pat(3'd4, 56'h53525150));
    sendByte(8'h50, 1'b0);
    sendByte(8'h51, 1'b0);
    sendByte(8'h52, 1'b0);
    sendByte(8'h53, 1'b1);
    expTok.push_back(tok(1'b0, 1'b0, 3'd0, 12'h0, 8'h50));
    expWr.push_back(64'h50);
    doSearch(3'd6, 12'h3AB);
    expPat.push_back(pat(3'd3, 56'h535251));
    expTok.push_back(tok(1'b1, 1'b1, 3'd3, 12'h00F, 8'h00));
    expWr.push_back(64'h51);
    expWr.push_back(64'h52);
    expWr.push_back(64'h53);
    doSearch(3'd3, 12'h00F);
    waitDrain("drainShort");

    // two-byte page ending in a match
    expPat.push_back(pat(3'd2, 56'hFC45));
    sendByte(8'h45, 1'b0);
    sendByte(8'hFC, 1'b1);
    expTok.push_back(tok(1'b1, 1'b1, 3'd2, 12'h010, 8'h00));
    expWr.push_back(64'h45);
    expWr.push_back(64'hFC);
    doSearch(3'd2, 12'h010);
    waitDrain("drainPage2");
    chk("pageEndReady", 64'(inDataReady), 64'(1));

    // token and write backpressure
    tokenReady     = 1'b0;
    writeDataReady = 1'b0;
    expPat.push_back(pat(3'd3, 56'h626160));
    sendByte(8'h60, 1'b0);
    sendByte(8'h61, 1'b0);
    sendByte(8'h62, 1'b1);
    expTok.push_back(tok(1'b1, 1'b1, 3'd3, 12'h7FF, 8'h00));
    expWr.push_back(64'h60);
    expWr.push_back(64'h61);
    expWr.push_back(64'h62);
    doSearch(3'd3, 12'h7FF);
    repeat (5) @(posedge clock);
    #1;
    chk("tokHeld", 64'(tokenValid), 64'(1));
    tokenReady = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      writeDataReady = !writeDataReady;
    end
    writeDataReady = 1'b1;
    waitDrain("drainBp");

    // inLast on the first byte
    expPat.push_back(pat(3'd1, 56'h99));
    sendByte(8'h99, 1'b1);
    expTok.push_back(tok(1'b0, 1'b1, 3'd0, 12'h0, 8'h99));
    expWr.push_back(64'h99);
    doSearch(3'd0, 12'h0);
    waitDrain("drainOne");

    // reset while two writes are pending
    writeDataReady = 1'b0;
    expPat.push_back(pat(3'd7, 56'h76757473727170));
    for (int i = 0; i < 7; i++) sendByte(8'(8'h70 + i), 1'b0);
    expTok.push_back(tok(1'b1, 1'b0, 3'd2, 12'h001, 8'h00));
    doSearch(3'd2, 12'h001);
    begin
      int t = 0;
      while (!writeDataValid && t < 50) begin
        @(posedge clock); #1; t++;
      end
      if (!writeDataValid) fail("commitTimeout");
    end
    reset = 1'b1;
    #1;
    chk("asyncRst", 64'({patternDataValid, matchResultReady,
        writeDataValid, tokenValid, inDataReady}), 64'(1));
    @(posedge clock); #1;
    chk("rstCycle", 64'({writeDataValid, writeData, inDataReady}),
        64'(1));
    reset          = 1'b0;
    writeDataReady = 1'b1;

    // page after reset starts from an empty window
    expPat.push_back(pat(3'd2, 56'h8180));
    sendByte(8'h80, 1'b0);
    sendByte(8'h81, 1'b1);
    expTok.push_back(tok(1'b0, 1'b0, 3'd0, 12'h0, 8'h80));
    expWr.push_back(64'h80);
    doSearch(3'd0, 12'h0);
    expPat.push_back(pat(3'd1, 56'h81));
    expTok.push_back(tok(1'b0, 1'b1, 3'd0, 12'h0, 8'h81));
    expWr.push_back(64'h81);
    doSearch(3'd0, 12'h0);
    waitDrain("drainFinal");
    chk("finalReady", 64'(inDataReady), 64'(1));
    chk("patLeft", 64'(expPat.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lz77_lookahead_controller.md
# lz77_lookahead_controller

Upstream control stage for the LZ77 single-cycle pattern search. It buffers the incoming byte stream into a 7-byte lookahead window and presents that window as a search pattern. It turns each match result into a literal or match token. It then commits the consumed bytes to the search history through the search block's write port, so a search never sees its own lookahead.

## Interface
Parameters:
- LOOKAHEAD, 7: lookahead window depth in bytes; equals the search block's pattern width.
- INDEX_WIDTH, 12: history index width (4 KB page).
- MIN_MATCH, 2: shortest match length emitted as a match token.

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- inDataValid  in  1  / inDataReady  out  1  / inData  in  8  / inLast  in  1: raw byte stream; inLast marks the final byte of a page
- patternDataValid  out  1  / patternDataReady  in  1  / patternData  out  8*LOOKAHEAD  / patternDataLength  out  3: search request; byte i at bits [8i+7:8i], byte 0 is oldest
- matchResultValid  in  1  / matchResultReady  out  1  / matchResultIndex  in  INDEX_WIDTH  / matchResultLength  in  3: search result
- writeDataValid  out  1  / writeDataReady  in  1  / writeData  out  8: history write port
- tokenValid  out  1  / tokenReady  in  1  / tokenIsMatch  out  1  / tokenLiteral  out  8  / tokenIndex  out  INDEX_WIDTH  / tokenLength  out  3  / tokenLast  out  1: token stream to the encoder

## Operation
- State: buffer[0:6], count (0..7), lastSeen flag, consume count n, FSM in {FILL, SEARCH, WAIT, EMIT, COMMIT}.
- FILL:
  - inDataReady = (count<7 && !lastSeen).
  - Each accepted byte goes to buffer[count], and count increments.
  - inLast sets lastSeen.
  - Leave to SEARCH when count==7, or when lastSeen && count>0.
- SEARCH:
  - patternDataValid=1.
  - patternData = buffer[0..count-1]. Bytes at count and above are driven 0.
  - patternDataLength = count.
  - On handshake, go to WAIT.
- WAIT:
  - matchResultReady=1.
  - On handshake, capture the index and L' = matchResultLength if MIN_MATCH ≤ length ≤ count, else 0.
  - Go to EMIT.
- EMIT:
  - tokenValid=1.
  - If L'>0: tokenIsMatch=1, tokenIndex=captured index, tokenLength=L', tokenLiteral=0.
  - If L'=0: tokenIsMatch=0, tokenLiteral=buffer[0], tokenIndex=0, tokenLength=0.
  - tokenLast = lastSeen && (max(L',1)==count).
  - On handshake, set n = max(L',1) and go to COMMIT.
- COMMIT:
  - writeDataValid=1 and writeData=buffer[0].
  - Each accepted write shifts the buffer down one byte, zero-fills buffer[6], and decrements both count and n.
  - When n reaches 0: if lastSeen && count==0, clear lastSeen; then return to FILL.
- Token and handshake output fields are stable while the corresponding valid is high and not yet accepted.
- Results with length >7 or > count are protocol errors. They are absorbed as literals and never stall the block.

## Timing
- Reset values:
  - All valid outputs 0, matchResultReady 0.
  - inDataReady 1 (FILL, count 0).
  - patternData, patternDataLength, writeData, all token fields, tokenLast 0.
  - count 0, lastSeen 0.
- Ready/valid rules:
  - Transfer occurs on a clock edge with valid && ready both high.
  - All outputs are decoded from registered state, with no combinational input-to-output path.
- Minimum per-step latency, assuming every ready is held high:
  - FILL→SEARCH on the edge that accepts the 7th byte.
  - 1 cycle SEARCH, ≥1 cycle WAIT, 1 cycle EMIT, n cycles COMMIT.
  - Refill takes n cycles.
- Backpressure:
  - A low tokenReady holds EMIT.
  - A low writeDataReady holds COMMIT, with no byte lost or duplicated.
- Boundary behaviour:
  - inLast on the 1st byte gives a pattern with length 1 and a literal token with tokenLast=1.
  - A page shorter than 7 bytes searches with count<7.
  - After a match, FILL resumes mid-window.
- Asynchronous reset mid-operation (any state) immediately clears all state. Buffer contents and pending tokens are discarded.

## Test plan
- Feed 0x41..0x47 (no inLast), result length 0 → pattern 0x47464544434241, length 7; literal token 0x41; one write 0x41; exactly one more byte accepted before the next SEARCH.
- Same window, result index 0x123 length 3 → match token index 0x123 length 3; writes 0x41,0x42,0x43 in order; count 4, then refill of 3 bytes.
- Result length 1 (below MIN_MATCH) and length 6 with count 4 → both emitted as literal buffer[0]; one byte committed each.
- Page of 2 bytes 0x45,0xFC with inLast on 0xFC, result length 2 index 0x010 → patternDataLength 2, upper bytes 0; match token with tokenLast=1; two writes; lastSeen cleared; inDataReady=1.
- Hold tokenReady low 5 cycles, then writeDataReady low alternate cycles → token fields stable throughout; history writes complete with no loss or duplication.
- Assert reset during COMMIT with 2 writes pending → next cycle all valids 0, inDataReady 1, count 0; subsequent page processes normally.
